// File: rtl/earth_pkg.sv
// -----------------------------------------------------------------------------
// earth_pkg
// Shared constants and types for the earth DRAM arbiter slice.
//   EARTH_ADDR_W / EARTH_DATA_W : default DRAM address and beat widths
//   EARTH_NUM_CL                : default number of DRAM clients
//   cl_id_t                     : client ID as stored in the read ID FIFO
// -----------------------------------------------------------------------------
package earth_pkg;
    localparam int EARTH_ADDR_W = 32;
    localparam int EARTH_DATA_W = 2048;
    localparam int EARTH_NUM_CL = 3;

    typedef logic [$clog2(EARTH_NUM_CL)-1:0] cl_id_t;
endpackage

// File: rtl/earth_rr_arb.sv
// -----------------------------------------------------------------------------
// earth_rr_arb
// N-way combinational round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : grant allowed this cycle (downstream has room)
//   req[N]     : request vector
//   gnt[N]     : one-hot grant, combinational
//   gnt_idx    : index of the granted requester (valid when |gnt)
// The pointer marks the highest-priority requester and moves one past the
// winner on every grant; it holds when nothing is granted.
// -----------------------------------------------------------------------------
module earth_rr_arb #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    // Scan from the pointer upwards, wrapping; first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (en && !found && req[(int'(ptr_q) + k) % N]) begin
                found                        = 1'b1;
                gnt[(int'(ptr_q) + k) % N]   = 1'b1;
                gnt_idx                      = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/earth_dram_arbiter.sv
// -----------------------------------------------------------------------------
// earth_dram_arbiter
// Shares one DRAM read port and one DRAM write port between NUM_CL clients.
// Reads and writes use independent round-robin arbiters. Issued read IDs go
// into an in-order ID FIFO so each dram_rd_valid beat is steered back to the
// client that issued it.
// Ports:
//   cl_rd_req/addr, cl_rd_gnt     : client read requests, combinational grant
//   cl_rd_valid/data              : one-hot response strobe, broadcast data
//   cl_wr_req/addr/data, cl_wr_gnt: client write requests, combinational grant
//   dram_rd_*                     : registered read command, in-order response
//   dram_wr_*                     : single-slot write command with ready
//   idle, err_unexp_rsp           : status (error is sticky until reset)
//   perf_*_cnt                    : counters, live only with
//                                   EARTH_DRAM_ARB_PERF_EN defined, else 0
// MAX_OUT must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module earth_dram_arbiter
    import earth_pkg::*;
#(
    parameter int NUM_CL  = EARTH_NUM_CL,
    parameter int ADDR_W  = EARTH_ADDR_W,
    parameter int DATA_W  = EARTH_DATA_W,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CL-1:0]        cl_rd_req,
    input  logic [NUM_CL*ADDR_W-1:0] cl_rd_addr,
    output logic [NUM_CL-1:0]        cl_rd_gnt,
    output logic [NUM_CL-1:0]        cl_rd_valid,
    output logic [DATA_W-1:0]        cl_rd_data,
    input  logic [NUM_CL-1:0]        cl_wr_req,
    input  logic [NUM_CL*ADDR_W-1:0] cl_wr_addr,
    input  logic [NUM_CL*DATA_W-1:0] cl_wr_data,
    output logic [NUM_CL-1:0]        cl_wr_gnt,
    output logic                     dram_rd_en,
    output logic [ADDR_W-1:0]        dram_rd_addr,
    input  logic [DATA_W-1:0]        dram_rd_data,
    input  logic                     dram_rd_valid,
    output logic                     dram_wr_en,
    output logic [ADDR_W-1:0]        dram_wr_addr,
    output logic [DATA_W-1:0]        dram_wr_data,
    input  logic                     dram_wr_ready,
    output logic                     idle,
    output logic                     err_unexp_rsp,
    output logic [31:0]              perf_rd_cnt,
    output logic [31:0]              perf_wr_cnt,
    output logic [31:0]              perf_stall_cnt
);
    localparam int ID_W = (NUM_CL > 1) ? $clog2(NUM_CL) : 1;
    localparam int PW   = $clog2(MAX_OUT);
    localparam int CW   = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    // ---------------- read path ----------------
    logic [ID_W-1:0]   fifo_q [MAX_OUT];
    logic [ID_W-1:0]   fifo_d [MAX_OUT];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              err_q, err_d;
    logic              rd_ok, rd_push, rd_pop;
    logic [ID_W-1:0]   rd_idx;

    // A full FIFO still accepts a grant when a response pops it this cycle.
    assign rd_ok   = (out_cnt_q < MAX_CNT) || dram_rd_valid;
    assign rd_pop  = dram_rd_valid && (out_cnt_q != '0);
    assign rd_push = |cl_rd_gnt;

    earth_rr_arb #(.N(NUM_CL), .IW(ID_W)) u_rd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (rd_ok),
        .req     (cl_rd_req),
        .gnt     (cl_rd_gnt),
        .gnt_idx (rd_idx)
    );

    always_comb begin
        fifo_d    = fifo_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        out_cnt_d = out_cnt_q;
        rd_en_d   = rd_push;
        rd_addr_d = rd_addr_q;
        err_d     = err_q || (dram_rd_valid && (out_cnt_q == '0));
        if (rd_push) begin
            fifo_d[wptr_q] = rd_idx;
            wptr_d         = wptr_q + 1'b1;
            rd_addr_d      = cl_rd_addr[int'(rd_idx)*ADDR_W +: ADDR_W];
        end
        if (rd_pop) rptr_d = rptr_q + 1'b1;
        case ({rd_push, rd_pop})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_comb begin
        cl_rd_valid = '0;
        cl_rd_data  = '0;
        if (rd_pop) begin
            cl_rd_valid[fifo_q[rptr_q]] = 1'b1;
            cl_rd_data                  = dram_rd_data;
        end
    end

    // ---------------- write path ----------------
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_drain, wr_ok, wr_push;
    logic [ID_W-1:0]   wr_idx;

    // The slot can be refilled in the same cycle it drains.
    assign wr_drain = wr_en_q && dram_wr_ready;
    assign wr_ok    = !wr_en_q || wr_drain;
    assign wr_push  = |cl_wr_gnt;

    earth_rr_arb #(.N(NUM_CL), .IW(ID_W)) u_wr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (wr_ok),
        .req     (cl_wr_req),
        .gnt     (cl_wr_gnt),
        .gnt_idx (wr_idx)
    );

    always_comb begin
        wr_en_d   = wr_en_q && !wr_drain;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (wr_push) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cl_wr_addr[int'(wr_idx)*ADDR_W +: ADDR_W];
            wr_data_d = cl_wr_data[int'(wr_idx)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            out_cnt_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            fifo_q    <= fifo_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            out_cnt_q <= out_cnt_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign dram_rd_en    = rd_en_q;
    assign dram_rd_addr  = rd_addr_q;
    assign dram_wr_en    = wr_en_q;
    assign dram_wr_addr  = wr_addr_q;
    assign dram_wr_data  = wr_data_q;
    assign err_unexp_rsp = err_q;
    assign idle          = (out_cnt_q == '0) && !wr_en_q && !rd_en_q;

    // ---------------- performance counters ----------------
`ifdef EARTH_DRAM_ARB_PERF_EN
    logic [31:0] prd_q, prd_d, pwr_q, pwr_d, pst_q, pst_d;

    always_comb begin
        prd_d = prd_q + 32'(rd_push);
        pwr_d = pwr_q + 32'(wr_drain);
        pst_d = pst_q + 32'((|cl_rd_req) && !rd_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prd_q <= '0;
            pwr_q <= '0;
            pst_q <= '0;
        end else begin
            prd_q <= prd_d;
            pwr_q <= pwr_d;
            pst_q <= pst_d;
        end
    end

    assign perf_rd_cnt    = prd_q;
    assign perf_wr_cnt    = pwr_q;
    assign perf_stall_cnt = pst_q;
`else
    assign perf_rd_cnt    = '0;
    assign perf_wr_cnt    = '0;
    assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_earth_dram_arbiter.sv
// Directed bench for earth_dram_arbiter. Inputs change and outputs are
// sampled 1ns after the falling edge; the DRAM side is driven by hand.
module tb_earth_dram_arbiter;
    localparam int NUM_CL  = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 2048;
    localparam int MAX_OUT = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CL-1:0]        cl_rd_req, cl_rd_gnt, cl_rd_valid;
    logic [NUM_CL*ADDR_W-1:0] cl_rd_addr;
    logic [DATA_W-1:0]        cl_rd_data;
    logic [NUM_CL-1:0]        cl_wr_req, cl_wr_gnt;
    logic [NUM_CL*ADDR_W-1:0] cl_wr_addr;
    logic [NUM_CL*DATA_W-1:0] cl_wr_data;
    logic                     dram_rd_en, dram_rd_valid;
    logic [ADDR_W-1:0]        dram_rd_addr;
    logic [DATA_W-1:0]        dram_rd_data;
    logic                     dram_wr_en, dram_wr_ready;
    logic [ADDR_W-1:0]        dram_wr_addr;
    logic [DATA_W-1:0]        dram_wr_data;
    logic                     idle, err_unexp_rsp;
    logic [31:0]              perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;

    always #5 clk = ~clk;

    earth_dram_arbiter #(
        .NUM_CL(NUM_CL), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cl_rd_req(cl_rd_req), .cl_rd_addr(cl_rd_addr), .cl_rd_gnt(cl_rd_gnt),
        .cl_rd_valid(cl_rd_valid), .cl_rd_data(cl_rd_data),
        .cl_wr_req(cl_wr_req), .cl_wr_addr(cl_wr_addr), .cl_wr_data(cl_wr_data),
        .cl_wr_gnt(cl_wr_gnt),
        .dram_rd_en(dram_rd_en), .dram_rd_addr(dram_rd_addr),
        .dram_rd_data(dram_rd_data), .dram_rd_valid(dram_rd_valid),
        .dram_wr_en(dram_wr_en), .dram_wr_addr(dram_wr_addr),
        .dram_wr_data(dram_wr_data), .dram_wr_ready(dram_wr_ready),
        .idle(idle), .err_unexp_rsp(err_unexp_rsp),
        .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // DRAM contents as seen by the bench: every word tagged with its address.
    function automatic logic [DATA_W-1:0] dram_mem(input logic [31:0] a);
        return {64{32'hD00D_0000 ^ a}};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [DATA_W-1:0] wdat;
    int ng;

    initial begin
        rst_n = 1'b0; cl_rd_req = '0; cl_rd_addr = '0; cl_wr_req = '0;
        cl_wr_addr = '0; cl_wr_data = '0; dram_rd_valid = 1'b0;
        dram_rd_data = '0; dram_wr_ready = 1'b0;
        wdat = {256{8'hA5}};
        cyc(); cyc(); #1;
        // reset state
        chk("rst_rd_en", dram_rd_en, 0);
        chk("rst_wr_en", dram_wr_en, 0);
        chk("rst_rd_addr", dram_rd_addr, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err_unexp_rsp, 0);
        chk("rst_perf_rd", perf_rd_cnt, 0);
        cyc(); rst_n = 1'b1;

        // ---- read contention, 1-cycle DRAM ----
        cyc(); cl_rd_req = 3'b111;
        cl_rd_addr[0*ADDR_W +: ADDR_W] = 32'd0;
        cl_rd_addr[1*ADDR_W +: ADDR_W] = 32'd1;
        cl_rd_addr[2*ADDR_W +: ADDR_W] = 32'd2;
        #1 chk("rc_gnt0", cl_rd_gnt, 3'b001);
        cyc(); cl_rd_req = 3'b110;
        #1 chk("rc_gnt1", cl_rd_gnt, 3'b010);
        chk("rc_en0", dram_rd_en, 1);
        chk("rc_addr0", dram_rd_addr, 0);
        cyc(); cl_rd_req = 3'b100; dram_rd_valid = 1'b1; dram_rd_data = dram_mem(0);
        #1 chk("rc_gnt2", cl_rd_gnt, 3'b100);
        chk("rc_addr1", dram_rd_addr, 1);
        chk("rc_val0", cl_rd_valid, 3'b001);
        chk("rc_dat0", 64'(cl_rd_data == dram_mem(0)), 1);
        cyc(); cl_rd_req = 3'b000; dram_rd_data = dram_mem(1);
        #1 chk("rc_gnt_none", cl_rd_gnt, 0);
        chk("rc_addr2", dram_rd_addr, 2);
        chk("rc_val1", cl_rd_valid, 3'b010);
        chk("rc_dat1", 64'(cl_rd_data == dram_mem(1)), 1);
        cyc(); dram_rd_data = dram_mem(2);
        #1 chk("rc_val2", cl_rd_valid, 3'b100);
        chk("rc_dat2", 64'(cl_rd_data == dram_mem(2)), 1);
        chk("rc_en_off", dram_rd_en, 0);
        chk("rc_busy", idle, 0);
        cyc(); dram_rd_valid = 1'b0; dram_rd_data = '0;
        #1 chk("rc_idle", idle, 1);

        // ---- outstanding limit ----
        cyc(); cl_rd_req = 3'b001; cl_rd_addr[0*ADDR_W +: ADDR_W] = 32'h10;
        #1;
        ng = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin cyc(); #1; end
            if (cl_rd_gnt == 3'b001) ng++;
        end
        chk("ol_grants", ng, 4);
        cyc();
`ifdef EARTH_DRAM_ARB_PERF_EN
        #1 chk("ol_stall", perf_stall_cnt, 4);
        chk("ol_perf_rd", perf_rd_cnt, 7);
`else
        #1 chk("ol_stall_off", perf_stall_cnt, 0);
`endif
        dram_rd_valid = 1'b1; dram_rd_data = dram_mem(32'h10);
        #1 chk("ol_release", cl_rd_gnt, 3'b001);
        chk("ol_val", cl_rd_valid, 3'b001);
        cyc(); dram_rd_valid = 1'b0;
        #1 chk("ol_block_again", cl_rd_gnt, 0);
        chk("ol_en", dram_rd_en, 1);
        chk("ol_addr", dram_rd_addr, 32'h10);
        cl_rd_req = 3'b000;
        for (int k = 0; k < 4; k++) begin
            cyc(); dram_rd_valid = 1'b1;
            #1 chk("ol_drain", cl_rd_valid, 3'b001);
        end
        cyc(); dram_rd_valid = 1'b0;
        #1 chk("ol_idle", idle, 1);
        chk("ol_err", err_unexp_rsp, 0);

        // ---- write backpressure ----
        cyc(); cl_wr_req = 3'b100; dram_wr_ready = 1'b0;
        cl_wr_addr[2*ADDR_W +: ADDR_W] = 32'd5;
        cl_wr_data[2*DATA_W +: DATA_W] = wdat;
        #1 chk("wb_gnt2", cl_wr_gnt, 3'b100);
        cyc(); cl_wr_req = 3'b001;
        cl_wr_addr[0*ADDR_W +: ADDR_W] = 32'd7;
        cl_wr_data[0*DATA_W +: DATA_W] = dram_mem(7);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            if (k == 3) dram_wr_ready = 1'b1;
            #1 chk("wb_en", dram_wr_en, 1);
            chk("wb_addr", dram_wr_addr, 5);
            chk("wb_data", 64'(dram_wr_data == wdat), 1);
            chk("wb_gnt", cl_wr_gnt, (k == 3) ? 3'b001 : 3'b000);
        end
        cyc(); cl_wr_req = 3'b000;
        #1 chk("wb_b2b_en", dram_wr_en, 1);
        chk("wb_b2b_addr", dram_wr_addr, 7);
        chk("wb_b2b_data", 64'(dram_wr_data == dram_mem(7)), 1);
        cyc();
        #1 chk("wb_done", dram_wr_en, 0);
        chk("wb_idle", idle, 1);

        // ---- simultaneous read and write ----
        cyc(); cl_rd_req = 3'b001; cl_rd_addr[0*ADDR_W +: ADDR_W] = 32'd3;
        cl_wr_req = 3'b010; cl_wr_addr[1*ADDR_W +: ADDR_W] = 32'd9;
        #1 chk("sw_rgnt", cl_rd_gnt, 3'b001);
        chk("sw_wgnt", cl_wr_gnt, 3'b010);
        cyc(); cl_rd_req = '0; cl_wr_req = '0;
        #1 chk("sw_rd_en", dram_rd_en, 1);
        chk("sw_wr_en", dram_wr_en, 1);
        chk("sw_wr_addr", dram_wr_addr, 9);

        // ---- unexpected response ----
        cyc(); dram_rd_valid = 1'b1; dram_rd_data = dram_mem(3);
        #1 chk("ur_val_ok", cl_rd_valid, 3'b001);
        cyc(); dram_rd_valid = 1'b0;
        #1 chk("ur_idle", idle, 1);
        cyc(); dram_rd_valid = 1'b1;
        #1 chk("ur_no_strobe", cl_rd_valid, 0);
        cyc(); dram_rd_valid = 1'b0;
        #1 chk("ur_err", err_unexp_rsp, 1);

        // ---- reset with two reads outstanding ----
        cyc(); cl_rd_req = 3'b011;
        cl_rd_addr[0*ADDR_W +: ADDR_W] = 32'h20;
        cl_rd_addr[1*ADDR_W +: ADDR_W] = 32'h21;
        #1 chk("rr_gnt1", cl_rd_gnt, 3'b010);
        chk("rr_err_sticky", err_unexp_rsp, 1);
        cyc(); cl_rd_req = 3'b001;
        #1 chk("rr_gnt0", cl_rd_gnt, 3'b001);
        chk("rr_addr", dram_rd_addr, 32'h21);
        cyc(); cl_rd_req = 3'b000;
        #1 chk("rr_busy", idle, 0);
        rst_n = 1'b0;
        #1 chk("rr_rd_en", dram_rd_en, 0);
        chk("rr_rd_addr", dram_rd_addr, 0);
        chk("rr_wr_en", dram_wr_en, 0);
        chk("rr_idle", idle, 1);
        chk("rr_err", err_unexp_rsp, 0);
        cyc(); rst_n = 1'b1;
        cyc(); dram_rd_valid = 1'b1;
        #1 chk("rr_late_strobe", cl_rd_valid, 0);
        cyc(); dram_rd_valid = 1'b0;
        #1 chk("rr_late_err", err_unexp_rsp, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
